// File: rtl/main_writeback.sv
// Y86-64 write-back stage: dstE/dstM decode, 15 x 64-bit register file with two read ports, status latch.
// Define WB_FORWARD_EN to bypass same-cycle writes onto the read ports.
module main_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] rdA,
  output logic [63:0] rdB,
  output logic [2:0]  stat,
  output logic        halted
);

  localparam int         NREG    = 15;
  localparam logic [3:0] RSP_IDX = 4'd4;
  localparam logic [3:0] RNONE   = 4'hF;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0, I_NOP   = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4, I_MRMOVQ = 4'h5, I_OPQ   = 4'h6, I_JXX    = 4'h7,
    I_CALL   = 4'h8, I_RET    = 4'h9, I_PUSHQ = 4'hA, I_POPQ   = 4'hB
  } icode_t;

  typedef enum logic [2:0] {
    S_AOK = 3'b001,
    S_HLT = 3'b010,
    S_INS = 3'b100
  } stat_t;

  logic [63:0] regs [NREG];
  stat_t       stat_q;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      I_RRMOVQ:                     dst_e = cnd ? rB : RNONE;
      I_IRMOVQ, I_OPQ:              dst_e = rB;
      I_CALL, I_RET, I_PUSHQ:       dst_e = RSP_IDX;
      I_POPQ: begin
        dst_e = RSP_IDX;
        dst_m = rA;
      end
      I_MRMOVQ:                     dst_m = rA;
      default: ;
    endcase
  end

  // NOTE: the register file is reset because the architecture defines all registers as zero after reset;
  // state is updated with non-blocking assignments so every reader sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      stat_q <= S_AOK;
    end else if (wb_valid && !halted) begin
      if (icode == I_HALT)
        stat_q <= S_HLT;
      else if (icode > I_POPQ)
        stat_q <= S_INS;
      // popq %rsp: the loaded value takes priority over the incremented pointer.
      if (dst_e != RNONE && dst_e != dst_m) regs[dst_e] <= valE;
      if (dst_m != RNONE)                   regs[dst_m] <= valM;
    end
  end

  assign stat   = stat_q;
  assign halted = (stat_q != S_AOK);

`ifdef WB_FORWARD_EN
  logic fwd_en;
  assign fwd_en = wb_valid && !halted;
`endif

  always_comb begin
    rdA = '0;
    if (srcA != RNONE) begin
      rdA = regs[srcA];
`ifdef WB_FORWARD_EN
      if (fwd_en && srcA == dst_m)      rdA = valM;
      else if (fwd_en && srcA == dst_e) rdA = valE;
`endif
    end
  end

  always_comb begin
    rdB = '0;
    if (srcB != RNONE) begin
      rdB = regs[srcB];
`ifdef WB_FORWARD_EN
      if (fwd_en && srcB == dst_m)      rdB = valM;
      else if (fwd_en && srcB == dst_e) rdB = valE;
`endif
    end
  end

endmodule

// File: tb/tb_main_writeback.sv
// Self-checking bench for main_writeback: directed scenarios followed by random instruction streams
// compared against an architectural model of the register file and status.
module tb_main_writeback;

  logic        clk = 1'b0;
  logic        reset, wb_valid, cnd;
  logic [3:0]  icode, rA, rB, srcA, srcB;
  logic [63:0] valE, valM, rdA, rdB;
  logic [2:0]  stat;
  logic        halted;

  localparam logic [2:0] AOK = 3'b001, HLT = 3'b010, INS = 3'b100;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mregs [15];
  logic [2:0]  mstat;

  main_writeback dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
    .rdA(rdA), .rdB(rdB), .stat(stat), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] want_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic c);
    if (ic == 4'h2)                     return c ? rb : 4'hF;
    if (ic inside {4'h3, 4'h6})         return rb;
    if (ic inside {[4'h8:4'hB]})        return 4'd4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] want_dst_m(input logic [3:0] ic, input logic [3:0] ra);
    return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] want_rd(input logic [3:0] src);
    logic [3:0] de, dm;
    if (src == 4'hF) return 64'd0;
    de = want_dst_e(icode, rB, cnd);
    dm = want_dst_m(icode, rA);
`ifdef WB_FORWARD_EN
    if (wb_valid && mstat == AOK) begin
      if (src == dm) return valM;
      if (src == de) return valE;
    end
`endif
    return mregs[src];
  endfunction

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Apply one cycle of stimulus, check outputs mid-cycle, then advance the model across the edge.
  task automatic step(input logic rst, input logic vld, input logic [3:0] ic, input logic [3:0] ra,
                      input logic [3:0] rb, input logic c, input logic [63:0] ve, input logic [63:0] vm,
                      input logic [3:0] sa, input logic [3:0] sb);
    logic [3:0] de, dm;
    reset = rst; wb_valid = vld; icode = ic; rA = ra; rB = rb; cnd = c;
    valE = ve; valM = vm; srcA = sa; srcB = sb;
    @(negedge clk);
    check("rdA", rdA, want_rd(sa));
    check("rdB", rdB, want_rd(sb));
    check("stat", {61'd0, stat}, {61'd0, mstat});
    check("halted", {63'd0, halted}, {63'd0, mstat != AOK});
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
      mstat = AOK;
    end else if (vld && mstat == AOK) begin
      if (ic == 4'h0)      mstat = HLT;
      else if (ic > 4'hB)  mstat = INS;
      else begin
        de = want_dst_e(ic, rb, c);
        dm = want_dst_m(ic, ra);
        if (de != 4'hF) mregs[de] = ve;
        if (dm != 4'hF) mregs[dm] = vm;
      end
    end
  endtask

  task automatic idle_read(input logic [3:0] sa, input logic [3:0] sb);
    step(1'b0, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, sa, sb);
  endtask

  initial begin
    int ic_pick;
    logic [3:0] ric;
    reset = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    valE = '0; valM = '0; srcA = 4'hF; srcB = 4'hF;
    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) mregs[i] = 64'd0;
    mstat = AOK;

    // Reset state of every register.
    for (int i = 0; i < 15; i += 2) idle_read(4'(i), 4'(i + 1));

    // irmovq into %rbx, then read it back.
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'd3, 1'b0, 64'h1234, 64'd0, 4'd3, 4'hF);
    idle_read(4'd3, 4'hF);

    // cmovXX not taken, then taken.
    step(1'b0, 1'b1, 4'h2, 4'd0, 4'd2, 1'b0, 64'd99, 64'd0, 4'd2, 4'd3);
    idle_read(4'd2, 4'd3);
    step(1'b0, 1'b1, 4'h2, 4'd0, 4'd2, 1'b1, 64'd99, 64'd0, 4'd2, 4'd3);
    idle_read(4'd2, 4'd3);

    // popq %rsp: valM wins. popq %rax: both written.
    step(1'b0, 1'b1, 4'hB, 4'd4, 4'hF, 1'b0, 64'h108, 64'h200, 4'd4, 4'd0);
    idle_read(4'd4, 4'd0);
    step(1'b0, 1'b1, 4'hB, 4'd0, 4'hF, 1'b0, 64'h108, 64'd7, 4'd4, 4'd0);
    idle_read(4'd4, 4'd0);

    // halt, then opq must be ignored; reset clears everything.
    step(1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 4'd1, 4'd4);
    step(1'b0, 1'b1, 4'h6, 4'd0, 4'd1, 1'b0, 64'd5, 64'd0, 4'd1, 4'd4);
    idle_read(4'd1, 4'd0);
    step(1'b1, 1'b1, 4'h6, 4'd0, 4'd1, 1'b0, 64'd5, 64'd0, 4'd1, 4'd4);
    for (int i = 0; i < 15; i += 2) idle_read(4'(i), 4'(i + 1));

    // Illegal instruction latches INS with no write.
    step(1'b0, 1'b1, 4'hD, 4'd2, 4'd2, 1'b1, 64'd11, 64'd12, 4'd2, 4'hF);
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'd2, 1'b0, 64'd13, 64'd0, 4'd2, 4'hF);
    step(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 4'd2, 4'hF);

    // mrmovq into %rsi with same-cycle read, then next-cycle read.
    step(1'b0, 1'b1, 4'h5, 4'd6, 4'hF, 1'b0, 64'd0, 64'd42, 4'd6, 4'd6);
    idle_read(4'd6, 4'hF);

    // Random instruction streams with occasional halts, illegal codes and resets.
    for (int n = 0; n < 400; n++) begin
      ic_pick = $urandom_range(0, 39);
      if (ic_pick == 0)      ric = 4'h0;
      else if (ic_pick == 1) ric = 4'($urandom_range(12, 15));
      else                   ric = 4'($urandom_range(1, 11));
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 7) != 0), ric,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           {$urandom, $urandom}, {$urandom, $urandom},
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/main_writeback.md
# main_writeback

Write-back stage and architectural register file for the sequential Y86-64 core, the write-side counterpart of the decode stage. Each valid cycle it derives `dstE`/`dstM` from `icode`, `rA`, `rB`, `cnd`, and commits `valE`/`valM` into fifteen 64-bit registers on the rising clock edge. It provides the two read ports the decode stage uses for `valA`/`valB`, and latches processor status on `halt` or an illegal instruction.

## Interface
- `NREG`, 15: architectural registers %rax..%r14, indices 0–14; index 15 (`RNONE`) means no register.
- `RSP_IDX`, 4: index of %rsp.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous reset, active-high.
- `wb_valid`  in  1  an instruction retires this cycle.
- `icode`  in  4  instruction code of the retiring instruction.
- `rA`, `rB`  in  4 each  register specifiers.
- `cnd`  in  1  condition result from execute (cmovXX).
- `valE`  in  64  ALU result.
- `valM`  in  64  memory read result.
- `srcA`, `srcB`  in  4 each  decode read addresses.
- `rdA`, `rdB`  out  64 each  read data.
- `stat`  out  3  status: AOK=3'b001, HLT=3'b010, INS=3'b100.
- `halted`  out  1  high whenever `stat` != AOK.

## Operation
- dstE decode:
  - icode 2 → `rB` if `cnd`=1, else `RNONE`.
  - icode 3, 6 → `rB`.
  - icode 8, 9, A, B → `RSP_IDX`.
  - otherwise → `RNONE`.
- dstM decode: icode 5, B → `rA`; otherwise → `RNONE`.
- Commit on rising `clk` when `wb_valid` && !`halted` && !`reset`:
  - reg[dstE] ← `valE` if dstE != 15.
  - reg[dstM] ← `valM` if dstM != 15.
- Same-register conflict, dstE == dstM (popq %rsp): `valM` wins and `valE` is dropped.
- icode 0 (halt) with `wb_valid`: no register write; `stat` ← HLT.
- icode > 4'hB with `wb_valid`: no register write; `stat` ← INS.
- Once `halted`, all further writes and status updates are ignored until `reset`.
- Read ports are combinational. `rdX` = reg[srcX], or 64'd0 when srcX == 15.
- Any `rB`/`rA` value of 15 selected as a destination is a no-op; this is not an error.

## Timing
- On `reset`: all 15 registers ← 64'd0, `stat` ← AOK, `halted` ← 0. Both take effect at the first rising edge with `reset` high.
- `reset` overrides a simultaneous `wb_valid`. A write presented in the same cycle as `reset` is lost.
- Write latency is one edge. The value is visible on `rdA`/`rdB` in the cycle after the commit edge, subject to the Configuration section.
- `halted` goes high in the cycle after the edge that sampled the halting instruction.
- `stat` and `halted` are registered outputs. `rdA`/`rdB` are combinational outputs.
- Throughput: one instruction per cycle. There is no backpressure.

## Configuration
- `WB_FORWARD_EN` defined: read ports bypass same-cycle writes.
  - If `wb_valid` && !`halted` and srcX equals the pending dstM, `rdX` = `valM`.
  - Otherwise, if srcX equals the pending dstE, `rdX` = `valE`.
  - Otherwise `rdX` = stored value.
  - The bypass applies the same dstM-over-dstE priority as the commit.
- `WB_FORWARD_EN` undefined: read ports show stored register contents only. A same-cycle write becomes visible one cycle later.

## Test plan
- Reset, then irmovq with `rB`=3, `valE`=64'h1234, `wb_valid`=1. Next cycle `srcA`=3 → `rdA`=64'h1234; `srcB`=15 → `rdB`=0; `stat`=AOK.
- cmovXX with `rB`=2, `valE`=99:
  - `cnd`=0 → reg2 stays 0.
  - Repeat with `cnd`=1 → reg2=99.
- popq with `rA`=4, `valE`=64'h108, `valM`=64'h200 → reg4=64'h200 (M wins).
- popq with `rA`=0, `valE`=64'h108, `valM`=7 → reg4=64'h108 and reg0=7 after one edge.
- halt (icode 0), then opq with `rB`=1, `valE`=5:
  - `stat`=HLT, `halted`=1, reg1 unchanged.
  - Assert `reset` for one cycle → all registers 0, `stat`=AOK.
- icode 4'hD → `stat`=INS, no write.
- With `WB_FORWARD_EN`: mrmovq with `rA`=6, `valM`=42, and `srcA`=6 in the same cycle → `rdA`=42 combinationally.
- Without `WB_FORWARD_EN`, the same stimulus gives `rdA`=0 in that cycle and 42 in the next.
